// File: rtl/tl_repeater_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_repeater_pkg
//  Description : Shared types for the TileLink A/D-channel beat repeaters:
//                A-channel opcodes, the fixed-width A header and the
//                repeater state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package tl_repeater_pkg;

    // TileLink A-channel opcodes
    localparam logic [2:0] TL_A_PUT_FULL      = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL   = 3'd1;
    localparam logic [2:0] TL_A_ARITHMETIC    = 3'd2;
    localparam logic [2:0] TL_A_LOGICAL       = 3'd3;
    localparam logic [2:0] TL_A_GET           = 3'd4;
    localparam logic [2:0] TL_A_HINT          = 3'd5;
    localparam logic [2:0] TL_A_ACQUIRE_BLOCK = 3'd6;
    localparam logic [2:0] TL_A_ACQUIRE_PERM  = 3'd7;

    // Width-independent part of an A beat; the parameter-width fields are
    // wrapped around this by the module that knows the widths.
    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] param;
    } tl_a_hdr_t;

    // Repeater FSM: IDLE passes beat 0 through, REPLAY emits saved beats
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REPLAY = 1'b1
    } rep_state_e;

endpackage : tl_repeater_pkg
`default_nettype wire

// File: rtl/tl_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tl_beat_counter
//  Description : Burst beat tracker. Load sets rem=count and beat=1 (beat 0
//                already left combinationally); each step decrements rem and
//                increments beat; last flags rem==1. Clear returns to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_beat_counter #(
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               clear_i,
    input  logic [COUNT_W-1:0] count_i,
    output logic [COUNT_W-1:0] beat_o,
    output logic               last_o
);

    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [COUNT_W-1:0] beat_q, beat_d;

    // Next-state: clear wins, then load, then step; otherwise hold
    always_comb begin
        rem_d  = rem_q;
        beat_d = beat_q;
        if (clear_i) begin
            rem_d  = '0;
            beat_d = '0;
        end else if (load_i) begin
            rem_d  = count_i;
            beat_d = COUNT_W'(1);
        end else if (step_i) begin
            rem_d  = rem_q - COUNT_W'(1);
            beat_d = beat_q + COUNT_W'(1);
        end
    end

    // Counter registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            beat_q <= '0;
        end else begin
            rem_q  <= rem_d;
            beat_q <= beat_d;
        end
    end

    assign beat_o = beat_q;
    assign last_o = (rem_q == COUNT_W'(1));

endmodule : tl_beat_counter
`default_nettype wire

// File: rtl/tl_a_burst_repeater.sv
`default_nettype none
// ============================================================================
//  Module      : tl_a_burst_repeater
//  Description : Accepts one TileLink A request and emits it count+1 times.
//                Beat 0 is a zero-latency pass-through; the remaining beats
//                replay saved payload with the address stepped by BEAT_BYTES
//                (modulo 2^ADDR_W). Mask and other fields are not modified.
//  Options     : TL_A_BURST_REPEATER_ABORT_EN adds io_abort, which drops the
//                remaining replay beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_a_burst_repeater
    import tl_repeater_pkg::*;
#(
    parameter int SOURCE_W   = 6,
    parameter int ADDR_W     = 33,
    parameter int BEAT_BYTES = 8,
    parameter int SIZE_W     = 3,
    parameter int COUNT_W    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  io_full,
    output logic                  io_enq_ready,
    input  logic                  io_enq_valid,
    input  logic [2:0]            io_enq_bits_opcode,
    input  logic [2:0]            io_enq_bits_param,
    input  logic [SIZE_W-1:0]     io_enq_bits_size,
    input  logic [SOURCE_W-1:0]   io_enq_bits_source,
    input  logic [ADDR_W-1:0]     io_enq_bits_address,
    input  logic [BEAT_BYTES-1:0] io_enq_bits_mask,
    input  logic [COUNT_W-1:0]    io_enq_count,
`ifdef TL_A_BURST_REPEATER_ABORT_EN
    input  logic                  io_abort,
`endif
    input  logic                  io_deq_ready,
    output logic                  io_deq_valid,
    output logic [2:0]            io_deq_bits_opcode,
    output logic [2:0]            io_deq_bits_param,
    output logic [SIZE_W-1:0]     io_deq_bits_size,
    output logic [SOURCE_W-1:0]   io_deq_bits_source,
    output logic [ADDR_W-1:0]     io_deq_bits_address,
    output logic [BEAT_BYTES-1:0] io_deq_bits_mask,
    output logic [COUNT_W-1:0]    io_deq_beat,
    output logic                  io_deq_last
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BEAT_BYTES);

    // Fields that are carried unchanged across every beat of a burst
    typedef struct packed {
        tl_a_hdr_t             hdr;
        logic [SIZE_W-1:0]     size;
        logic [SOURCE_W-1:0]   source;
        logic [BEAT_BYTES-1:0] mask;
    } tl_a_bits_t;

    rep_state_e         state_q, state_d;
    tl_a_bits_t         saved_q;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    tl_a_bits_t         w_enq_bits;
    tl_a_bits_t         w_out_bits;
    logic               w_full;
    logic               w_enq_fire;
    logic               w_deq_fire;
    logic               w_abort;
    logic               w_load;
    logic               w_step;
    logic               w_clear;
    logic [COUNT_W-1:0] w_cnt_beat;
    logic               w_cnt_last;

`ifdef TL_A_BURST_REPEATER_ABORT_EN
    assign w_abort = io_abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_enq_bits.hdr.opcode = io_enq_bits_opcode;
    assign w_enq_bits.hdr.param  = io_enq_bits_param;
    assign w_enq_bits.size       = io_enq_bits_size;
    assign w_enq_bits.source     = io_enq_bits_source;
    assign w_enq_bits.mask       = io_enq_bits_mask;

    assign w_full       = (state_q == ST_REPLAY);
    assign io_full      = w_full;
    assign io_enq_ready = io_deq_ready & ~w_full;
    assign io_deq_valid = io_enq_valid | w_full;
    assign w_enq_fire   = io_enq_valid & io_enq_ready;
    assign w_deq_fire   = io_deq_valid & io_deq_ready;

    // Next-state and counter control; abort only matters while replaying
    always_comb begin
        state_d = state_q;
        w_load  = 1'b0;
        w_step  = 1'b0;
        w_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_enq_fire && (io_enq_count != '0)) begin
                    state_d = ST_REPLAY;
                    w_load  = 1'b1;
                end
            end
            ST_REPLAY: begin
                if (w_deq_fire) begin
                    if (w_cnt_last || w_abort) begin
                        state_d = ST_IDLE;
                        w_clear = 1'b1;
                    end else begin
                        w_step = 1'b1;
                    end
                end else if (w_abort) begin
                    state_d = ST_IDLE;
                    w_clear = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                w_clear = 1'b1;
            end
        endcase
    end

    // Replay address: beat-0 address plus one step on load, one step per beat
    always_comb begin
        addr_d = addr_q;
        if (w_load) begin
            addr_d = io_enq_bits_address + ADDR_STEP;
        end else if (w_step) begin
            addr_d = addr_q + ADDR_STEP;
        end
    end

    // State register, asynchronously forced to IDLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Saved payload: no reset, only sampled on an accepted multi-beat request
    always_ff @(posedge clock) begin
        if (w_load) begin
            saved_q <= w_enq_bits;
        end
        if (w_load || w_step) begin
            addr_q <= addr_d;
        end
    end

    tl_beat_counter #(
        .COUNT_W (COUNT_W)
    ) u_beat_counter (
        .clk     (clock),
        .rst     (reset),
        .load_i  (w_load),
        .step_i  (w_step),
        .clear_i (w_clear),
        .count_i (io_enq_count),
        .beat_o  (w_cnt_beat),
        .last_o  (w_cnt_last)
    );

    assign w_out_bits          = w_full ? saved_q : w_enq_bits;
    assign io_deq_bits_opcode  = w_out_bits.hdr.opcode;
    assign io_deq_bits_param   = w_out_bits.hdr.param;
    assign io_deq_bits_size    = w_out_bits.size;
    assign io_deq_bits_source  = w_out_bits.source;
    assign io_deq_bits_mask    = w_out_bits.mask;
    assign io_deq_bits_address = w_full ? addr_q : io_enq_bits_address;
    assign io_deq_beat         = w_full ? w_cnt_beat : '0;
    assign io_deq_last         = w_full ? w_cnt_last : (io_enq_count == '0);

endmodule : tl_a_burst_repeater
`default_nettype wire
